// File: rtl/ann_weight_pkg.sv
// Shared widths and the reader FSM state type for the ANN layer weight path.
// Default widths describe one neuron's weight BRAM; the stream readers derive their parameters from them.
package ann_weight_pkg;
    localparam int WEIGHT_W           = 16;
    localparam int WEIGHT_ADDR_W      = 5;
    localparam int WEIGHTS_PER_NEURON = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } reader_state_t;
endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry valid/ready FIFO carrying {data, idx, last} from the BRAM read port to the MAC.
// Latency: a word pushed on an edge is at the head after that edge if the buffer was empty.
// Backpressure: holds the head stable while pop_rdy is low; the producer must not push when full.
module weight_skid_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic [ADDR_W-1:0] push_idx,
    input  logic              push_last,
    input  logic              pop_rdy,
    output logic              head_vld,
    output logic [DATA_W-1:0] head_dat,
    output logic [ADDR_W-1:0] head_idx,
    output logic              head_last,
    output logic [1:0]        count
);
    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } entry_t;

    entry_t     ent0_q, ent0_d, ent1_q, ent1_d, in_ent;
    logic [1:0] cnt_q, cnt_d;
    logic       pop, push;

    assign in_ent = {push_dat, push_idx, push_last};
    assign pop    = pop_rdy && (cnt_q != 2'd0);
    assign push   = push_vld && ((cnt_q != 2'd2) || pop);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = in_ent;
                else               ent1_d = in_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = in_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_vld  = (cnt_q != 2'd0);
    assign head_dat  = ent0_q.dat;
    assign head_idx  = ent0_q.idx;
    assign head_last = ent0_q.last;
    assign count     = cnt_q;
endmodule

// File: rtl/weight_stream_reader.sv
// Streams addresses 0..DEPTH-1 of a negedge weight BRAM to a MAC; WEIGHT_READER_LOAD_EN adds an IDLE-time loader.
// Latency: START at edge N issues address 0 after N, W_VALID after N+1; one word/cycle with W_READY high.
// Backpressure: reads issue only while buffered + in-flight words stay within the 2-entry skid buffer.
module weight_stream_reader
    import ann_weight_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DEPTH  = WEIGHTS_PER_NEURON
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
`ifdef WEIGHT_READER_LOAD_EN
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_W-1:0] BRAM_DI,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_DATA,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic              W_LAST,
    output logic [ADDR_W-1:0] W_IDX
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, addr_q, addr_d;
    logic              en_q, en_d, inflight_q, inflight_d;
    logic              buf_vld, buf_last, pop, credit, ld_take;
    logic [1:0]        buf_cnt, occ_next;
    logic [DATA_W-1:0] buf_dat;
    logic [ADDR_W-1:0] buf_idx;

`ifdef WEIGHT_READER_LOAD_EN
    logic              we_q, we_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    assign ld_take = LD_VALID && (state_q == IDLE);
`else
    assign ld_take = 1'b0;
`endif

    // Occupancy as it will stand after this edge: the word in flight lands, the head may leave.
    assign pop      = buf_vld && W_READY;
    assign occ_next = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
    assign credit   = (occ_next < 2'd2);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        en_d       = 1'b0;
        inflight_d = 1'b0;
`ifdef WEIGHT_READER_LOAD_EN
        we_d       = 1'b0;
        di_d       = '0;
        ld_ptr_d   = ld_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (ld_take) begin
`ifdef WEIGHT_READER_LOAD_EN
                    en_d     = 1'b1;
                    we_d     = 1'b1;
                    di_d     = LD_DATA;
                    addr_d   = ld_ptr_q;
                    ld_ptr_d = (ld_ptr_q == LAST_ADDR) ? '0 : ld_ptr_q + ADDR_W'(1);
`endif
                end else if (START) begin
                    state_d    = RUN;
                    en_d       = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = '0;
                    rd_ptr_d   = ADDR_W'(1);
                end
            end
            RUN: begin
                if (credit) begin
                    en_d       = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = rd_ptr_q;
                    if (rd_ptr_q == LAST_ADDR) state_d  = DRAIN;
                    else                       rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (pop && buf_last) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            inflight_q <= 1'b0;
`ifdef WEIGHT_READER_LOAD_EN
            we_q       <= 1'b0;
            di_q       <= '0;
            ld_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            inflight_q <= inflight_d;
`ifdef WEIGHT_READER_LOAD_EN
            we_q       <= we_d;
            di_q       <= di_d;
            ld_ptr_q   <= ld_ptr_d;
`endif
        end
    end

    // The BRAM holds DO between reads, so only the edge after an issued read captures it.
    weight_skid_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push_vld  (inflight_q),
        .push_dat  (BRAM_DO),
        .push_idx  (addr_q),
        .push_last (addr_q == LAST_ADDR),
        .pop_rdy   (W_READY),
        .head_vld  (buf_vld),
        .head_dat  (buf_dat),
        .head_idx  (buf_idx),
        .head_last (buf_last),
        .count     (buf_cnt)
    );

    assign BUSY      = (state_q == RUN) || (state_q == DRAIN);
    assign DONE      = (state_q == FIN);
    assign BRAM_EN   = en_q;
    assign BRAM_ADDR = addr_q;
`ifdef WEIGHT_READER_LOAD_EN
    assign BRAM_WE   = we_q;
    assign BRAM_DI   = di_q;
`else
    assign BRAM_WE   = 1'b0;
    assign BRAM_DI   = '0;
`endif
    assign W_VALID   = buf_vld;
    assign W_DATA    = buf_dat;
    assign W_IDX     = buf_idx;
    assign W_LAST    = buf_last;
endmodule

// File: tb/tb_weight_stream_reader.sv
// Bench for weight_stream_reader: negedge BRAM model plus a scoreboard of the words each pass must deliver.
module tb_weight_stream_reader;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 28;

    logic          CLK     = 1'b0;
    logic          RST_N   = 1'b1;
    logic          START   = 1'b0;
    logic          W_READY = 1'b0;
    logic          BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST;
    logic [AW-1:0] BRAM_ADDR, W_IDX;
    logic [DW-1:0] BRAM_DI, W_DATA;
    logic [DW-1:0] BRAM_DO = '0;
`ifdef WEIGHT_READER_LOAD_EN
    logic          LD_VALID = 1'b0;
    logic [DW-1:0] LD_DATA  = '0;
`endif

    logic [DW-1:0] mem      [32];
    logic [DW-1:0] init_img [32];
    logic          init_req = 1'b0;
    logic [DW-1:0] exp_mem  [DEPTH];
    int            nvec = 0;
    int            nerr = 0;

    always #5 CLK = ~CLK;

    // BRAM: samples EN/WE/ADDR/DI on the falling edge, holds DO when not reading.
    always @(negedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_img[i];
        end else if (BRAM_EN) begin
            if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
            else         BRAM_DO        <= mem[BRAM_ADDR];
        end
    end

    weight_stream_reader dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
`ifdef WEIGHT_READER_LOAD_EN
        .LD_VALID  (LD_VALID),
        .LD_DATA   (LD_DATA),
`endif
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
        .W_DATA    (W_DATA),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_LAST    (W_LAST),
        .W_IDX     (W_IDX)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            init_img[i] = rnd ? 16'($urandom) : (16'h0100 + 16'(i));
            if (i < DEPTH) exp_mem[i] = init_img[i];
        end
        init_req = 1'b1;
        @(negedge CLK);
        #1;
        init_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        #2;
        nvec++;
        if ({BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_flags: busy/done/en/we/vld/last=%b want 000000",
                     {BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST});
        end
        nvec++;
        if (BRAM_ADDR !== '0 || BRAM_DI !== '0) begin
            nerr++;
            $display("FAIL reset_bram: addr=%0d di=%h want 0 0", BRAM_ADDR, BRAM_DI);
        end
        nvec++;
        if (W_DATA !== '0 || W_IDX !== '0) begin
            nerr++;
            $display("FAIL reset_stream: data=%h idx=%0d want 0 0", W_DATA, W_IDX);
        end
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        tick();
        nvec++;
        if (BUSY !== 1'b0 || W_VALID !== 1'b0 || BRAM_EN !== 1'b0) begin
            nerr++;
            $display("FAIL idle_after_reset: busy=%b vld=%b en=%b want 0 0 0", BUSY, W_VALID, BRAM_EN);
        end
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1; 2: random ready; 3: random ready + START at word 5 and in FIN.
    task automatic test_pass(input int mode);
        int            k = 0, reads = 0, dones = 0, cyc = 0;
        bit            hold = 1'b0, restarted = 1'b0, rdy = 1'b0;
        logic [DW-1:0] hd = '0;
        logic [AW-1:0] hi = '0;
        logic          hl = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        nvec++;
        if (BUSY !== 1'b1 || W_VALID !== 1'b0 || BRAM_EN !== 1'b1 || BRAM_ADDR !== '0) begin
            nerr++;
            $display("FAIL start_issue m%0d: busy=%b vld=%b en=%b addr=%0d want 1 0 1 0",
                     mode, BUSY, W_VALID, BRAM_EN, BRAM_ADDR);
        end
        while (dones == 0 && cyc < 400) begin
            if (BRAM_EN && !BRAM_WE) reads++;
            nvec++;
            if (reads - k > 2) begin
                nerr++;
                $display("FAIL outstanding m%0d: %0d words buffered/in flight, limit 2", mode, reads - k);
            end
            if (W_VALID) begin
                nvec++;
                if (W_LAST !== (W_IDX == AW'(DEPTH - 1))) begin
                    nerr++;
                    $display("FAIL last_flag m%0d: last=%b at idx %0d", mode, W_LAST, W_IDX);
                end
            end
            if (hold) begin
                nvec++;
                if (W_VALID !== 1'b1 || W_DATA !== hd || W_IDX !== hi || W_LAST !== hl) begin
                    nerr++;
                    $display("FAIL stall_stable m%0d: vld=%b %h@%0d last=%b want 1 %h@%0d last=%b",
                             mode, W_VALID, W_DATA, W_IDX, W_LAST, hd, hi, hl);
                end
            end
            if (mode == 0 && cyc == 1) begin
                nvec++;
                if (W_VALID !== 1'b1) begin
                    nerr++;
                    $display("FAIL first_valid: vld=%b two edges after START, want 1", W_VALID);
                end
            end
            if (DONE) begin
                dones++;
                nvec++;
                if (k !== DEPTH || BUSY !== 1'b0) begin
                    nerr++;
                    $display("FAIL done_at m%0d: words=%0d busy=%b want %0d 0", mode, k, BUSY, DEPTH);
                end
                if (mode == 3) START = 1'b1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if (mode == 3 && k == 5 && !restarted) begin
                    START     = 1'b1;
                    restarted = 1'b1;
                end
                W_READY = rdy;
                if (W_VALID && rdy) begin
                    nvec++;
                    if (k >= DEPTH) begin
                        nerr++;
                        $display("FAIL extra_word m%0d: idx=%0d beyond pass", mode, W_IDX);
                    end else if (W_DATA !== exp_mem[k] || W_IDX !== AW'(k)) begin
                        nerr++;
                        $display("FAIL word m%0d: got %h@%0d want %h@%0d", mode, W_DATA, W_IDX, exp_mem[k], k);
                    end
                    k++;
                    if (mode == 0 && k == DEPTH) begin
                        nvec++;
                        if (cyc + 1 !== DEPTH + 1) begin
                            nerr++;
                            $display("FAIL pass_cycles: last handshake %0d cycles after START want %0d",
                                     cyc + 1, DEPTH + 1);
                        end
                    end
                end
                hold = W_VALID && !rdy;
                hd   = W_DATA;
                hi   = W_IDX;
                hl   = W_LAST;
            end
            tick();
            START = 1'b0;
            cyc++;
        end
        nvec++;
        if (dones !== 1) begin
            nerr++;
            $display("FAIL done_count m%0d: %0d DONE pulses within budget want 1", mode, dones);
        end
        nvec++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || BRAM_EN !== 1'b0 || W_VALID !== 1'b0) begin
            nerr++;
            $display("FAIL after_done m%0d: done=%b busy=%b en=%b vld=%b want 0 0 0 0",
                     mode, DONE, BUSY, BRAM_EN, W_VALID);
        end
        W_READY = 1'b0;
    endtask

    task automatic test_stall10();
        int            reads = 0, k = 0, cyc = 0;
        logic [AW-1:0] a [$];
        W_READY = 1'b0;
        START   = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (BRAM_EN && !BRAM_WE) begin
                reads++;
                a.push_back(BRAM_ADDR);
            end
            tick();
        end
        nvec++;
        if (reads !== 2) begin
            nerr++;
            $display("FAIL stall_reads: %0d reads while stalled want 2", reads);
        end
        nvec++;
        if (a.size() < 2) begin
            nerr++;
            $display("FAIL stall_addrs: only %0d addresses seen want 0,1", a.size());
        end else if (a[0] !== AW'(0) || a[1] !== AW'(1)) begin
            nerr++;
            $display("FAIL stall_addrs: %0d,%0d want 0,1", a[0], a[1]);
        end
        nvec++;
        if (W_VALID !== 1'b1 || W_IDX !== '0 || W_DATA !== exp_mem[0]) begin
            nerr++;
            $display("FAIL stall_head: vld=%b %h@%0d want 1 %h@0", W_VALID, W_DATA, W_IDX, exp_mem[0]);
        end
        W_READY = 1'b1;
        while (!DONE && cyc < 100) begin
            if (W_VALID) begin
                nvec++;
                if (k >= DEPTH || W_IDX !== AW'(k) || W_DATA !== exp_mem[k % DEPTH]) begin
                    nerr++;
                    $display("FAIL resume_word: got %h@%0d want word %0d", W_DATA, W_IDX, k);
                end
                k++;
            end
            tick();
            cyc++;
        end
        nvec++;
        if (k !== DEPTH || DONE !== 1'b1) begin
            nerr++;
            $display("FAIL resume_done: words=%0d done=%b want %0d 1", k, DONE, DEPTH);
        end
        tick();
        W_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit dseen = 1'b0;
        W_READY = 1'b1;
        START   = 1'b1;
        tick();
        START = 1'b0;
        while (!(W_VALID && W_IDX == AW'(12)) && cyc < 100) begin
            tick();
            cyc++;
        end
        nvec++;
        if (W_VALID !== 1'b1 || W_IDX !== AW'(12)) begin
            nerr++;
            $display("FAIL reach_word12: vld=%b idx=%0d want 1 12", W_VALID, W_IDX);
        end
        #2 RST_N = 1'b0;
        #1;
        nvec++;
        if ({BUSY, DONE, BRAM_EN, W_VALID, W_LAST} !== 5'b0 || W_DATA !== '0 || W_IDX !== '0
            || BRAM_ADDR !== '0) begin
            nerr++;
            $display("FAIL midreset_outputs: busy/done/en/vld/last=%b data=%h idx=%0d addr=%0d want all 0",
                     {BUSY, DONE, BRAM_EN, W_VALID, W_LAST}, W_DATA, W_IDX, BRAM_ADDR);
        end
        tick();
        RST_N = 1'b1;
        repeat (5) begin
            tick();
            if (DONE) dseen = 1'b1;
        end
        nvec++;
        if (dseen || BUSY !== 1'b0 || W_VALID !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_abort: done_seen=%b busy=%b vld=%b want 0 0 0", dseen, BUSY, W_VALID);
        end
        W_READY = 1'b0;
    endtask

`ifdef WEIGHT_READER_LOAD_EN
    task automatic test_load();
        for (int i = 0; i < DEPTH; i++) begin
            LD_VALID   = 1'b1;
            LD_DATA    = 16'hA000 + 16'(i);
            exp_mem[i] = LD_DATA;
            tick();
            nvec++;
            if (BRAM_EN !== 1'b1 || BRAM_WE !== 1'b1 || BRAM_ADDR !== AW'(i) || BRAM_DI !== exp_mem[i]) begin
                nerr++;
                $display("FAIL load_write %0d: en=%b we=%b addr=%0d di=%h want 1 1 %0d %h",
                         i, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, i, exp_mem[i]);
            end
        end
        LD_VALID = 1'b0;
        tick();
        test_pass(0);
        LD_VALID = 1'b1;
        LD_DATA  = 16'hB0B0;
        START    = 1'b1;
        tick();
        LD_VALID = 1'b0;
        START    = 1'b0;
        nvec++;
        if (BUSY !== 1'b0 || BRAM_WE !== 1'b1 || BRAM_ADDR !== '0 || BRAM_DI !== 16'hB0B0) begin
            nerr++;
            $display("FAIL load_wrap: busy=%b we=%b addr=%0d di=%h want 0 1 0 b0b0",
                     BUSY, BRAM_WE, BRAM_ADDR, BRAM_DI);
        end
        exp_mem[0] = 16'hB0B0;
        tick();
        test_pass(0);
    endtask
`endif

    initial begin
        test_reset();
        fill(1'b0);
        test_pass(0);
        test_pass(1);
        test_stall10();
        test_pass(3);
        test_reset_mid();
        test_pass(0);
        fill(1'b1);
        test_pass(2);
        test_pass(2);
        test_pass(3);
`ifdef WEIGHT_READER_LOAD_EN
        test_load();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
